// File: rtl/blur_pkg.sv
// blur_pkg: shared constants and types for the vertical Gaussian pass.
// Holds kernel weights, shift amounts, widths and the frame state enum.
package blur_pkg;
    localparam int DATA_W = 18;
    localparam int ACC_W  = 28;
    localparam int NTAPS  = 11;
    localparam int SH5    = 8;
    localparam int SH11   = 20;
    localparam int ROWS5  = 4;
    localparam int ROWS11 = 10;
    // 5-tap weights padded with zeros so both kernels share one 11-tap datapath
    localparam logic [7:0] K5 [NTAPS] = '{8'd1, 8'd4, 8'd6, 8'd4, 8'd1,
                                          8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic [7:0] K11 [NTAPS] = '{8'd1, 8'd10, 8'd45, 8'd120, 8'd210, 8'd252,
                                           8'd210, 8'd120, 8'd45, 8'd10, 8'd1};
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic logic [7:0] weight(input logic sel, input int k);
        return sel ? K11[k] : K5[k];
    endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one row of storage, combinational read-before-write at addr.
// The read value is the data from the previous row at the same column.
module line_buffer
    import blur_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 640,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rd
);
    logic [WIDTH-1:0] mem [DEPTH];
    assign rd = mem[addr];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end
endmodule

// File: rtl/vertical_conv.sv
// vertical_conv: column-wise binomial blur (5 or 11 tap) on row-filtered data.
// Define ROUND_EN for round-to-nearest with saturation; default truncates.
module vertical_conv
    import blur_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int NUM_LINES  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              toggle,
    input  logic              sof,
    input  logic [DATA_W-1:0] pixel_in_horiz,
    input  logic              in_valid,
    output logic [7:0]        pixel_out,
    output logic              out_valid,
    output logic              frame_done
);
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    state_t            state, state_n;
    logic [COL_W-1:0]  col, bcol;
    logic [ROW_W-1:0]  row, brow;
    logic              kern_sel;
    logic              accept, start, restart, last_col, last_beat, warm;
    logic              s1_valid;
    logic [DATA_W-1:0] ch [NUM_LINES+1];
    logic [DATA_W-1:0] taps [NUM_LINES+1];
    logic [ACC_W-1:0]  acc;
    logic [4:0]        sh;
    logic [7:0]        pix;

    // A sof beat always counts as col 0 / row 0, whatever the counters hold
    always_comb begin
        accept    = in_valid && (sof || state == RUN);
        start     = accept && sof;
        restart   = start && state == RUN;
        bcol      = start ? '0 : col;
        brow      = start ? '0 : row;
        last_col  = bcol == COL_W'(IMG_WIDTH - 1);
        last_beat = last_col && brow == ROW_W'(IMG_HEIGHT - 1);
        warm      = int'(brow) >= (kern_sel ? ROWS11 : ROWS5);
        state_n   = accept ? (last_beat ? DONE : RUN) : (state == DONE ? IDLE : state);
    end

    assign ch[0] = pixel_in_horiz;
    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        line_buffer #(.WIDTH(DATA_W), .DEPTH(IMG_WIDTH)) u_line (
            .clk  (clk),
            .we   (accept),
            .addr (bcol),
            .din  (ch[i]),
            .rd   (ch[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (accept) taps <= ch;
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++)
            acc = acc + ACC_W'(taps[k]) * ACC_W'(weight(kern_sel, k));
    end

    assign sh = kern_sel ? 5'(SH11) : 5'(SH5);

`ifdef ROUND_EN
    localparam int RW = ACC_W + 1;
    logic [RW-1:0] rnd, shifted;
    always_comb begin
        rnd     = {1'b0, acc} + (RW'(1) << (sh - 5'd1));
        shifted = rnd >> sh;
        pix     = |shifted[RW-1:8] ? 8'hFF : shifted[7:0];
    end
`else
    assign pix = 8'(acc >> sh);
`endif

    // A restart drops whatever the aborted frame still has in stage 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            kern_sel   <= 1'b0;
            s1_valid   <= 1'b0;
            out_valid  <= 1'b0;
            pixel_out  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            frame_done <= state == DONE;
            out_valid  <= s1_valid && !restart;
            s1_valid   <= accept && warm;
            if (s1_valid && !restart) pixel_out <= pix;
            if (start) kern_sel <= toggle;
            if (accept) begin
                col <= last_col ? '0 : bcol + 1'b1;
                row <= last_beat ? '0 : (last_col ? brow + 1'b1 : brow);
            end
        end
    end
endmodule

// File: tb/tb_vertical_conv.sv
// tb_vertical_conv: directed frames with a queued scoreboard on a 16x16 image.
// Expected pixel values and arrival cycles are pushed at stimulus time.
module tb_vertical_conv;
    localparam int W = 16;
    localparam int H = 16;
`ifdef ROUND_EN
    localparam logic [7:0] RND_EXP = 8'd188;
`else
    localparam logic [7:0] RND_EXP = 8'd187;
`endif

    logic        clk = 0, rst_n = 0, toggle = 0, sof = 0, in_valid = 0;
    logic [17:0] pixel_in_horiz = '0;
    logic [7:0]  pixel_out;
    logic        out_valid, frame_done;

    vertical_conv #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_LINES(10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .toggle         (toggle),
        .sof            (sof),
        .pixel_in_horiz (pixel_in_horiz),
        .in_valid       (in_valid),
        .pixel_out      (pixel_out),
        .out_valid      (out_valid),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        int         cyc;
    } exp_t;

    exp_t eq[$];
    int   fq[$];
    exp_t mon_e;
    int   mon_f;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   last_cyc = 0;
    logic chk_req = 0;
    logic fin_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Beat captured at the next edge; output visible two edges later
    task automatic beat(input logic [17:0] v, input logic s, input logic t,
                        input logic e, input logic [7:0] p);
        @(posedge clk); #1;
        in_valid = 1; sof = s; toggle = t; pixel_in_horiz = v;
        if (e) eq.push_back('{p, cyc + 2});
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 0; sof = 0;
        end
    endtask

    task automatic frame(input logic t, input logic [17:0] v, input logic [7:0] p, input int gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                beat(v, r == 0 && c == 0, t, r >= (t ? 10 : 4), p);
                if (gap > 0 && (r * W + c) % gap == gap - 1) idle(1);
            end
        fq.push_back(last_cyc + 2);
    endtask

    always @(negedge clk) begin
        if (chk_req) begin
            total++;
            if (out_valid === 1'b0 && pixel_out === 8'd0 && frame_done === 1'b0) passed++;
            else $display("FAIL reset_state: out_valid=%b pixel_out=%0d frame_done=%b, need 0 0 0",
                          out_valid, pixel_out, frame_done);
        end
        if (out_valid === 1'b1) begin
            total++;
            if (eq.size() == 0)
                $display("FAIL unexpected_output: pixel_out=%0d at cycle %0d, none expected", pixel_out, cyc);
            else begin
                mon_e = eq.pop_front();
                if (pixel_out === mon_e.pix && cyc == mon_e.cyc) passed++;
                else $display("FAIL pixel: got %0d at cycle %0d, need %0d at cycle %0d",
                              pixel_out, cyc, mon_e.pix, mon_e.cyc);
            end
        end
        if (frame_done === 1'b1) begin
            total++;
            if (fq.size() == 0)
                $display("FAIL unexpected_frame_done: at cycle %0d, none expected", cyc);
            else begin
                mon_f = fq.pop_front();
                if (cyc == mon_f) passed++;
                else $display("FAIL frame_done: at cycle %0d, need cycle %0d", cyc, mon_f);
            end
        end
        if (fin_req) begin
            total++;
            if (eq.size() == 0 && fq.size() == 0) passed++;
            else $display("FAIL missing_outputs: %0d pixels and %0d frame_done still pending, need 0 0",
                          eq.size(), fq.size());
            $display("%0d/%0d checks passed", passed, total);
            $finish;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1; chk_req = 1;
        @(posedge clk); #1 chk_req = 0;

        frame(1'b0, 18'd4080, 8'd255, 0);
        idle(3);
        frame(1'b1, 18'd102400, 8'd100, 0);
        idle(3);

        // impulse at row 2 col 3 spreads over centre rows 2,3,4 with weights 6,4,1
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                beat((r == 2 && c == 3) ? 18'd4096 : 18'd0, r == 0 && c == 0, 1'b0, r >= 4,
                     c != 3 ? 8'd0 : r == 4 ? 8'd96 : r == 5 ? 8'd64 : r == 6 ? 8'd16 : 8'd0);
        fq.push_back(last_cyc + 2);
        idle(3);

        frame(1'b1, 18'd102400, 8'd100, 5);
        idle(3);

        // toggle flipped mid-frame must not switch kernels; sof at row 5 restarts
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < W; c++)
                beat(18'd4080, r == 0 && c == 0, r >= 1 && r <= 3, r == 4, 8'd255);
        idle(1);
        frame(1'b0, 18'd4080, 8'd255, 0);
        idle(3);

        // reset one cycle after the row 6 col 0 beat kills its pending output
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < W; c++)
                beat(18'd4080, r == 0 && c == 0, 1'b0, r >= 4, 8'd255);
        beat(18'd4080, 1'b0, 1'b0, 1'b0, 8'd0);
        @(posedge clk); #1 rst_n = 0; in_valid = 0; sof = 0;
        @(posedge clk); #1 rst_n = 1; chk_req = 1;
        @(posedge clk); #1 chk_req = 0;
        for (int i = 0; i < 20; i++) beat(18'd4080, 1'b0, 1'b0, 1'b0, 8'd0);
        idle(2);
        frame(1'b0, 18'd4080, 8'd255, 0);
        idle(3);

        frame(1'b0, 18'd3000, RND_EXP, 0);
        idle(4);
        fin_req = 1;
    end
endmodule
